// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - memory game sequencer: fetches one random digit per round, plays the sequence back, checks keys
module memory_game_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auth_bit,
  input  logic       start_pulse,
  input  logic [3:0] rng_num,
  input  logic       rng_enable,
  input  logic       key_pulse,
  input  logic [3:0] key_num,
  output logic       rng_req,
  output logic [3:0] disp_num,
  output logic       disp_valid,
  output logic [3:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RNG, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE
  } state_t;

  localparam logic [3:0]  MAX_L     = 4'(MAX_LEN);
  localparam logic [15:0] SHOW_LAST = 16'(SHOW_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic [3:0]  seq_mem [16];
  logic [3:0]  len;
  logic [3:0]  idx;
  logic [15:0] timer;

  always_ff @(posedge clk) begin
    if (rst || !auth_bit) begin
      state      <= S_IDLE;
      len        <= 4'd0;
      idx        <= 4'd0;
      timer      <= 16'd0;
      rng_req    <= 1'b0;
      disp_num   <= 4'd0;
      disp_valid <= 1'b0;
      round      <= 4'd0;
      busy       <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      rng_req <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_pulse) begin
            state   <= S_FETCH;
            len     <= 4'd1;
            idx     <= 4'd0;
            round   <= 4'd1;
            busy    <= 1'b1;
            win     <= 1'b0;
            lose    <= 1'b0;
            rng_req <= 1'b1;
          end
        end
        S_FETCH: state <= S_WAIT_RNG;
        S_WAIT_RNG: begin
          if (rng_enable) begin
            seq_mem[len - 4'd1] <= rng_num;
            idx        <= 4'd0;
            timer      <= 16'd0;
            state      <= S_SHOW;
            disp_valid <= 1'b1;
            // In round 1 the digit being shown is the one arriving right now
            disp_num   <= (len == 4'd1) ? rng_num : seq_mem[0];
          end
        end
        S_SHOW: begin
          if (timer == SHOW_LAST) begin
            timer      <= 16'd0;
            state      <= S_GAP;
            disp_valid <= 1'b0;
            disp_num   <= 4'd0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= 16'd0;
            if (idx + 4'd1 == len) begin
              idx   <= 4'd0;
              state <= S_INPUT;
            end else begin
              idx        <= idx + 4'd1;
              state      <= S_SHOW;
              disp_valid <= 1'b1;
              disp_num   <= seq_mem[idx + 4'd1];
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_INPUT: begin
          if (key_pulse) begin
            if (key_num != seq_mem[idx]) begin
              state <= S_LOSE;
              lose  <= 1'b1;
              busy  <= 1'b0;
            end else if (idx != len - 4'd1) begin
              idx <= idx + 4'd1;
            end else if (len == MAX_L) begin
              state <= S_WIN;
              win   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              len     <= len + 4'd1;
              round   <= len + 4'd1;
              idx     <= 4'd0;
              state   <= S_FETCH;
              rng_req <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb/tb_memory_game_ctrl.sv - randomized self-checking bench against a queue-based model of the game
module tb_memory_game_ctrl;

  localparam int MAXL = 3;
  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       auth_bit = 1'b0;
  logic       start_pulse = 1'b0;
  logic [3:0] rng_num = 4'd0;
  logic       rng_enable = 1'b0;
  logic       key_pulse = 1'b0;
  logic [3:0] key_num = 4'd0;
  logic       rng_req;
  logic [3:0] disp_num;
  logic       disp_valid;
  logic [3:0] round;
  logic       busy;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];

  memory_game_ctrl #(.MAX_LEN(MAXL), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .auth_bit(auth_bit), .start_pulse(start_pulse),
    .rng_num(rng_num), .rng_enable(rng_enable), .key_pulse(key_pulse), .key_num(key_num),
    .rng_req(rng_req), .disp_num(disp_num), .disp_valid(disp_valid), .round(round),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; auth_bit = 1'b0;
    tick(); tick();
    checks++;
    if ({rng_req, disp_num, disp_valid, round, busy, win, lose} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero", {rng_req, disp_num, disp_valid, round, busy, win, lose});
    end
    rst = 1'b0; start_pulse = 1'b1;
    tick();
    checks++;
    if ({rng_req, disp_num, disp_valid, round, busy, win, lose} !== 13'd0) begin
      errors++;
      $display("FAIL start_no_auth: got %b want all zero", {rng_req, disp_num, disp_valid, round, busy, win, lose});
    end
    rst = 1'b1; auth_bit = 1'b1;
    tick();
    checks++;
    if ({rng_req, disp_num, disp_valid, round, busy, win, lose} !== 13'd0) begin
      errors++;
      $display("FAIL rst_with_start: got %b want all zero", {rng_req, disp_num, disp_valid, round, busy, win, lose});
    end
    rst = 1'b0; start_pulse = 1'b0;
    tick();
  endtask

  task automatic go_idle();
    auth_bit = 1'b0;
    tick();
    checks++;
    if ({rng_req, disp_num, disp_valid, round, busy, win, lose} !== 13'd0) begin
      errors++;
      $display("FAIL auth_drop_idle: got %b want all zero", {rng_req, disp_num, disp_valid, round, busy, win, lose});
    end
    auth_bit = 1'b1;
  endtask

  task automatic begin_game();
    auth_bit = 1'b1; start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    q.delete();
    checks++;
    if (rng_req !== 1'b1 || round !== 4'd1 || busy !== 1'b1 || win !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL start_fetch: rng_req=%b round=%0d busy=%b win=%b lose=%b want 1 1 1 0 0",
               rng_req, round, busy, win, lose);
    end
  endtask

  // Called with the DUT in FETCH; returns with the first SHOW cycle visible.
  task automatic rng_answer(input logic [3:0] d, input int delay);
    tick();
    checks++;
    if (rng_req !== 1'b0 || busy !== 1'b1 || disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rng_req_one_cycle: rng_req=%b busy=%b valid=%b want 0 1 0", rng_req, busy, disp_valid);
    end
    for (int k = 0; k < delay; k++) begin
      tick();
      checks++;
      if (rng_req !== 1'b0 || disp_valid !== 1'b0 || busy !== 1'b1 || round !== 4'(q.size() + 1)) begin
        errors++;
        $display("FAIL wait_rng: rng_req=%b valid=%b busy=%b round=%0d want 0 0 1 %0d",
                 rng_req, disp_valid, busy, round, q.size() + 1);
      end
    end
    rng_enable = 1'b1; rng_num = d;
    tick();
    rng_enable = 1'b0; rng_num = 4'($urandom_range(0, 15));
    q.push_back(d);
  endtask

  // Walks the expected playback cycle by cycle; noise inputs must all be ignored.
  task automatic check_playback(input bit noise);
    for (int i = 0; i < q.size(); i++) begin
      for (int c = 0; c < SHOW + GAP; c++) begin
        checks++;
        if (c < SHOW) begin
          if (disp_valid !== 1'b1 || disp_num !== q[i] || busy !== 1'b1 || round !== 4'(q.size())) begin
            errors++;
            $display("FAIL show d%0d c%0d: valid=%b num=%0d busy=%b round=%0d want 1 %0d 1 %0d",
                     i, c, disp_valid, disp_num, busy, round, q[i], q.size());
          end
        end else begin
          if (disp_valid !== 1'b0 || disp_num !== 4'd0 || busy !== 1'b1 || lose !== 1'b0) begin
            errors++;
            $display("FAIL gap d%0d c%0d: valid=%b num=%0d busy=%b lose=%b want 0 0 1 0",
                     i, c, disp_valid, disp_num, busy, lose);
          end
        end
        if (noise) begin
          key_pulse   = 1'($urandom_range(0, 1));
          key_num     = 4'($urandom_range(0, 15));
          start_pulse = 1'($urandom_range(0, 1));
          rng_enable  = 1'($urandom_range(0, 1));
          rng_num     = 4'($urandom_range(0, 15));
        end
        tick();
      end
    end
    key_pulse = 1'b0; start_pulse = 1'b0; rng_enable = 1'b0;
  endtask

  task automatic enter_keys(input int wrong_at, input logic [3:0] wrong_val);
    bit done = 1'b0;
    for (int i = 0; i < q.size() && !done; i++) begin
      for (int w = $urandom_range(0, 2); w > 0; w--) begin
        rng_enable = 1'($urandom_range(0, 1));
        tick();
        rng_enable = 1'b0;
        checks++;
        if (disp_valid !== 1'b0 || busy !== 1'b1 || rng_req !== 1'b0 || lose !== 1'b0) begin
          errors++;
          $display("FAIL input_idle: valid=%b busy=%b rng_req=%b lose=%b want 0 1 0 0",
                   disp_valid, busy, rng_req, lose);
        end
      end
      key_pulse = 1'b1;
      key_num   = (i == wrong_at) ? wrong_val : q[i];
      tick();
      key_pulse = 1'b0;
      checks++;
      if (i == wrong_at) begin
        done = 1'b1;
        if (lose !== 1'b1 || busy !== 1'b0 || win !== 1'b0 || round !== 4'(q.size())) begin
          errors++;
          $display("FAIL wrong_key: lose=%b busy=%b win=%b round=%0d want 1 0 0 %0d",
                   lose, busy, win, round, q.size());
        end
      end else if (i < q.size() - 1) begin
        if (busy !== 1'b1 || rng_req !== 1'b0 || lose !== 1'b0 || win !== 1'b0) begin
          errors++;
          $display("FAIL partial_key %0d: busy=%b rng_req=%b lose=%b win=%b want 1 0 0 0",
                   i, busy, rng_req, lose, win);
        end
      end else if (q.size() == MAXL) begin
        if (win !== 1'b1 || busy !== 1'b0 || lose !== 1'b0 || round !== 4'(MAXL)) begin
          errors++;
          $display("FAIL win: win=%b busy=%b lose=%b round=%0d want 1 0 0 %0d", win, busy, lose, round, MAXL);
        end
      end else begin
        if (rng_req !== 1'b1 || round !== 4'(q.size() + 1) || busy !== 1'b1 || lose !== 1'b0) begin
          errors++;
          $display("FAIL next_round: rng_req=%b round=%0d busy=%b lose=%b want 1 %0d 1 0",
                   rng_req, round, busy, lose, q.size() + 1);
        end
      end
    end
  endtask

  task automatic test_round_one();
    begin_game();
    rng_answer(4'd9, 1);
    check_playback(1'b0);
    enter_keys(-1, 4'd0);
  endtask

  task automatic test_two_digit();
    rng_answer(4'd3, 0);
    check_playback(1'b0);
    enter_keys(-1, 4'd0);
  endtask

  task automatic test_lose_restart();
    go_idle();
    begin_game();
    rng_answer(4'd9, 0);
    check_playback(1'b0);
    enter_keys(-1, 4'd0);
    rng_answer(4'd3, 1);
    check_playback(1'b0);
    enter_keys(1, 4'd5);
    for (int k = 0; k < 3; k++) begin
      key_pulse = 1'b1; key_num = 4'($urandom_range(0, 15));
      tick();
      key_pulse = 1'b0;
      checks++;
      if (lose !== 1'b1 || busy !== 1'b0 || round !== 4'd2 || rng_req !== 1'b0) begin
        errors++;
        $display("FAIL lose_hold: lose=%b busy=%b round=%0d rng_req=%b want 1 0 2 0", lose, busy, round, rng_req);
      end
    end
    begin_game();
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 4; g++) begin
      int wrong_round = (g % 2 == 0) ? -1 : int'($urandom_range(0, MAXL - 1));
      bit lost = 1'b0;
      go_idle();
      begin_game();
      for (int r = 0; r < MAXL && !lost; r++) begin
        rng_answer(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        check_playback(1'b1);
        if (r == wrong_round) begin
          int pos = int'($urandom_range(0, r));
          enter_keys(pos, q[pos] ^ 4'($urandom_range(1, 15)));
          lost = 1'b1;
        end else begin
          enter_keys(-1, 4'd0);
        end
      end
      key_pulse = 1'b1; key_num = 4'($urandom_range(0, 15)); rng_enable = 1'b1;
      tick();
      key_pulse = 1'b0; rng_enable = 1'b0;
      checks++;
      if (win !== !lost || lose !== lost || busy !== 1'b0 || rng_req !== 1'b0) begin
        errors++;
        $display("FAIL end_hold g%0d: win=%b lose=%b busy=%b rng_req=%b want %b %b 0 0",
                 g, win, lose, busy, rng_req, !lost, lost);
      end
    end
  endtask

  task automatic test_auth_drop();
    go_idle();
    begin_game();
    rng_answer(4'd7, 0);
    tick(); tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_num !== 4'd7) begin
      errors++;
      $display("FAIL pre_drop_show: valid=%b num=%0d want 1 7", disp_valid, disp_num);
    end
    go_idle();
  endtask

  task automatic test_rst_mid_input();
    go_idle();
    begin_game();
    rng_answer(4'd4, 0);
    check_playback(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rng_req, disp_num, disp_valid, round, busy, win, lose} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid_input: got %b want all zero", {rng_req, disp_num, disp_valid, round, busy, win, lose});
    end
    key_pulse = 1'b1; key_num = 4'd4;
    tick();
    key_pulse = 1'b0;
    checks++;
    if ({rng_req, disp_num, disp_valid, round, busy, win, lose} !== 13'd0) begin
      errors++;
      $display("FAIL key_in_idle: got %b want all zero", {rng_req, disp_num, disp_valid, round, busy, win, lose});
    end
  endtask

  initial begin
    test_reset();
    test_round_one();
    test_two_digit();
    test_lose_restart();
    test_random_games();
    test_auth_drop();
    test_rst_mid_input();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_game_ctrl.md
# memory_game_ctrl

Sequencing controller for the memory tester game. It sits between the RNG block, the digit display and the player keypad. For each round it requests one new random digit from the RNG and appends it to a stored sequence. It then plays the whole sequence back on the display and checks the player's key entries against it, ending in a win or a lose.

## Interface
- MAX_LEN, 8: maximum sequence length (rounds to win); 1..15.
- SHOW_CYCLES, 4: cycles each digit is displayed; ≥1.
- GAP_CYCLES, 2: blank cycles after each displayed digit; ≥1.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high; overrides every other input.
- auth_bit  in  1  player authenticated; low forces IDLE.
- start_pulse  in  1  one-cycle start/restart request.
- rng_num  in  4  random digit from RNG.
- rng_enable  in  1  rng_num valid this cycle.
- key_pulse  in  1  one-cycle player key strobe.
- key_num  in  4  player digit, valid with key_pulse.
- rng_req  out  1  one-cycle request to RNG (drives its button_pulse).
- disp_num  out  4  digit being shown; 0 when disp_valid=0.
- disp_valid  out  1  display digit active.
- round  out  4  current sequence length; 0 in IDLE.
- busy  out  1  game in progress (not IDLE/WIN/LOSE).
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.

## Operation
- State buffer: MAX_LEN×4-bit digit array, len counter, idx counter, phase timer.
- States: IDLE, FETCH, WAIT_RNG, SHOW, GAP, INPUT, WIN, LOSE.
- IDLE: on start_pulse & auth_bit → len=1, FETCH.
- FETCH: rng_req=1 (this state only) → WAIT_RNG.
- WAIT_RNG: wait indefinitely. On rng_enable, buf[len-1]=rng_num, idx=0 → SHOW. rng_enable in any other state is ignored.
- SHOW: disp_valid=1, disp_num=buf[idx]. After SHOW_CYCLES cycles → GAP.
- GAP: outputs blank for GAP_CYCLES cycles. Then idx+1. If idx+1==len → INPUT with idx=0; otherwise → SHOW.
- INPUT: on key_pulse, compare key_num with buf[idx]:
  - mismatch → LOSE.
  - match with idx<len-1 → idx+1.
  - match with idx==len-1 and len==MAX_LEN → WIN.
  - match with idx==len-1 otherwise → len+1, FETCH.
- Existing digits are never regenerated; each round appends exactly one digit.
- WIN/LOSE: flag held, round holds final len. On start_pulse & auth_bit → restart exactly as from IDLE (len=1, FETCH).
- Inputs outside their accepting state are ignored: key_pulse outside INPUT, start_pulse while busy.
- auth_bit=0 in any state → IDLE next cycle. All outputs clear and buffer contents are don't-care.
- No timeout in INPUT.

## Timing
- Reset: state IDLE. All outputs 0 (rng_req, disp_num, disp_valid, round, busy, win, lose). Counters 0.
- All outputs are registered Moore outputs of the current state and counters.
- start_pulse sampled at edge N → FETCH at N+1 (rng_req=1, busy=1, round=1) → WAIT_RNG at N+2.
- rng_enable sampled at edge M in WAIT_RNG → SHOW from M+1 with the new digit visible.
- Playback of length n takes exactly n·(SHOW_CYCLES+GAP_CYCLES) cycles. INPUT is entered the cycle after the last gap cycle.
- Final correct key at edge K → FETCH at K+1 (round increments that cycle), or WIN at K+1.
- Wrong key at edge K → LOSE at K+1, lose=1, busy=0.
- Simultaneous events:
  - rst wins over everything.
  - auth_bit=0 wins over start, key and rng_enable.
  - key_pulse coincident with the INPUT-entry edge is ignored (not yet in INPUT).

## Test plan
- Reset/gating: rst=1 two cycles, then start_pulse with auth_bit=0 → all outputs stay 0, state IDLE; rst and start together → IDLE.
- Round 1: auth_bit=1, start_pulse; RNG answers rng_num=9 two cycles after rng_req → rng_req exactly one cycle; disp_num=9 with disp_valid=1 for 4 cycles, then 2 blank; key 9 → round=2, rng_req pulses again.
- Two-digit playback: second digit 3 → display shows 9 (4 cycles), blank 2, then 3 (4 cycles), blank 2, total 12 cycles. Keys 9,3 → round=3.
- Lose and restart: sequence [9,3], keys 9 then 5 → lose=1, busy=0, round=2 held; start_pulse → lose=0, round=1, rng_req=1.
- Win with MAX_LEN=3: all entries correct → win=1 after third round. A key_pulse during SHOW is ignored and does not cause lose.
- Auth drop: auth_bit=0 mid-SHOW → next cycle disp_valid=0, round=0, busy=0. rst mid-INPUT → all outputs 0 next cycle.
